// File: rtl/axi_mux_pkg.sv
// Shared types and constants for the 2:1 AXI master mux.
// arb_pick is the common AR/AW grant rule: hold a locked grant, else prefer `pref` on contention.
package axi_mux_pkg;

  typedef logic mux_sel_t;

  localparam mux_sel_t SEL_M0 = 1'b0;
  localparam mux_sel_t SEL_M1 = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic mux_sel_t arb_pick(input logic     locked,
                                        input mux_sel_t lock_sel,
                                        input logic     v0,
                                        input logic     v1,
                                        input mux_sel_t pref);
    if (locked)   return lock_sel;
    if (v0 && v1) return pref;
    return v1 ? SEL_M1 : SEL_M0;
  endfunction

endpackage

// File: rtl/axi_mux_wsel_fifo.sv
// W-route FIFO: records the master index of each accepted AW so W beats follow AW order.
// Push and pop on an empty FIFO in one cycle is legal (AW/W bypass) and leaves it empty.
module axi_mux_wsel_fifo
  import axi_mux_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset_l,
  input  logic     push,
  input  mux_sel_t push_sel,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output mux_sel_t head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  mux_sel_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & (~empty | do_push);

  // NOTE: storage is not reset; count and pointers decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_sel;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_2to1_master_mux.sv
// Merges m0 (IFU) and m1 (LSU) onto one AXI slave port; slave ID MSB tags the source master.
// Define AXI_MUX_FIXED_PRIO_EN to make m1 win every simultaneous AR/AW request.
module axi_2to1_master_mux
  import axi_mux_pkg::*;
#(
  parameter int M_ID_WIDTH = 8,
  parameter int WSEL_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_l,
  // m0
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  input  logic [M_ID_WIDTH-1:0] m0_arid,
  input  logic [31:0]           m0_araddr,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  output logic [63:0]           m0_rdata,
  output logic [M_ID_WIDTH-1:0] m0_rid,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rlast,
  input  logic                  m0_awvalid,
  output logic                  m0_awready,
  input  logic [M_ID_WIDTH-1:0] m0_awid,
  input  logic [31:0]           m0_awaddr,
  input  logic                  m0_wvalid,
  output logic                  m0_wready,
  input  logic [63:0]           m0_wdata,
  input  logic [7:0]            m0_wstrb,
  output logic                  m0_bvalid,
  input  logic                  m0_bready,
  output logic [M_ID_WIDTH-1:0] m0_bid,
  output logic [1:0]            m0_bresp,
  // m1
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  input  logic [M_ID_WIDTH-1:0] m1_arid,
  input  logic [31:0]           m1_araddr,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  output logic [63:0]           m1_rdata,
  output logic [M_ID_WIDTH-1:0] m1_rid,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rlast,
  input  logic                  m1_awvalid,
  output logic                  m1_awready,
  input  logic [M_ID_WIDTH-1:0] m1_awid,
  input  logic [31:0]           m1_awaddr,
  input  logic                  m1_wvalid,
  output logic                  m1_wready,
  input  logic [63:0]           m1_wdata,
  input  logic [7:0]            m1_wstrb,
  output logic                  m1_bvalid,
  input  logic                  m1_bready,
  output logic [M_ID_WIDTH-1:0] m1_bid,
  output logic [1:0]            m1_bresp,
  // slave
  output logic                  s_arvalid,
  input  logic                  s_arready,
  output logic [M_ID_WIDTH:0]   s_arid,
  output logic [31:0]           s_araddr,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  input  logic [63:0]           s_rdata,
  input  logic [M_ID_WIDTH:0]   s_rid,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rlast,
  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [M_ID_WIDTH:0]   s_awid,
  output logic [31:0]           s_awaddr,
  output logic                  s_wvalid,
  input  logic                  s_wready,
  output logic [63:0]           s_wdata,
  output logic [7:0]            s_wstrb,
  input  logic                  s_bvalid,
  output logic                  s_bready,
  input  logic [M_ID_WIDTH:0]   s_bid,
  input  logic [1:0]            s_bresp
);

  // Handshake outputs are held low until the first clock after reset release.
  logic     active;
  logic     ar_lock, aw_lock;
  mux_sel_t ar_lock_sel, aw_lock_sel;
  mux_sel_t ar_pref, aw_pref;
  mux_sel_t ar_grant, aw_grant;
  logic     ar_gvalid, aw_gvalid, ar_hs, aw_hs;
  logic     wsel_full, wsel_empty, w_route_ok, w_pop;
  mux_sel_t wsel_head, w_route;
  mux_sel_t r_sel, b_sel;

  // ---------------- AR ----------------
  assign ar_grant   = arb_pick(ar_lock, ar_lock_sel, m0_arvalid, m1_arvalid, ar_pref);
  assign ar_gvalid  = active & ((ar_grant == SEL_M1) ? m1_arvalid : m0_arvalid);
  assign ar_hs      = ar_gvalid & s_arready;
  assign s_arvalid  = ar_gvalid;
  assign s_arid     = {ar_grant, (ar_grant == SEL_M1) ? m1_arid : m0_arid};
  assign s_araddr   = (ar_grant == SEL_M1) ? m1_araddr : m0_araddr;
  assign m0_arready = active & s_arready & (ar_grant == SEL_M0);
  assign m1_arready = active & s_arready & (ar_grant == SEL_M1);

  // ---------------- AW (blocked while the W-route FIFO is full) ----------------
  assign aw_grant   = arb_pick(aw_lock, aw_lock_sel, m0_awvalid, m1_awvalid, aw_pref);
  assign aw_gvalid  = active & ~wsel_full & ((aw_grant == SEL_M1) ? m1_awvalid : m0_awvalid);
  assign aw_hs      = aw_gvalid & s_awready;
  assign s_awvalid  = aw_gvalid;
  assign s_awid     = {aw_grant, (aw_grant == SEL_M1) ? m1_awid : m0_awid};
  assign s_awaddr   = (aw_grant == SEL_M1) ? m1_awaddr : m0_awaddr;
  assign m0_awready = active & ~wsel_full & s_awready & (aw_grant == SEL_M0);
  assign m1_awready = active & ~wsel_full & s_awready & (aw_grant == SEL_M1);

  // ---------------- W: FIFO head, or the AW grant when bypassing an empty FIFO ----------------
  assign w_route_ok = active & (~wsel_empty | aw_hs);
  assign w_route    = wsel_empty ? aw_grant : wsel_head;
  assign s_wvalid   = w_route_ok & ((w_route == SEL_M1) ? m1_wvalid : m0_wvalid);
  assign s_wdata    = (w_route == SEL_M1) ? m1_wdata : m0_wdata;
  assign s_wstrb    = (w_route == SEL_M1) ? m1_wstrb : m0_wstrb;
  assign m0_wready  = w_route_ok & s_wready & (w_route == SEL_M0);
  assign m1_wready  = w_route_ok & s_wready & (w_route == SEL_M1);
  assign w_pop      = s_wvalid & s_wready;

  axi_mux_wsel_fifo #(.DEPTH(WSEL_DEPTH)) u_wsel_fifo (
    .clk      (clk),
    .reset_l  (reset_l),
    .push     (aw_hs),
    .push_sel (aw_grant),
    .pop      (w_pop),
    .full     (wsel_full),
    .empty    (wsel_empty),
    .head     (wsel_head)
  );

  // ---------------- R / B routed by tag MSB ----------------
  assign r_sel     = s_rid[M_ID_WIDTH];
  assign m0_rvalid = active & s_rvalid & (r_sel == SEL_M0);
  assign m1_rvalid = active & s_rvalid & (r_sel == SEL_M1);
  assign s_rready  = active & ((r_sel == SEL_M1) ? m1_rready : m0_rready);
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;
  assign m0_rid    = s_rid[M_ID_WIDTH-1:0];
  assign m1_rid    = s_rid[M_ID_WIDTH-1:0];
  assign m0_rresp  = s_rresp;
  assign m1_rresp  = s_rresp;
  assign m0_rlast  = s_rlast;
  assign m1_rlast  = s_rlast;

  assign b_sel     = s_bid[M_ID_WIDTH];
  assign m0_bvalid = active & s_bvalid & (b_sel == SEL_M0);
  assign m1_bvalid = active & s_bvalid & (b_sel == SEL_M1);
  assign s_bready  = active & ((b_sel == SEL_M1) ? m1_bready : m0_bready);
  assign m0_bid    = s_bid[M_ID_WIDTH-1:0];
  assign m1_bid    = s_bid[M_ID_WIDTH-1:0];
  assign m0_bresp  = s_bresp;
  assign m1_bresp  = s_bresp;

  // NOTE: sequential state uses non-blocking assignments; the grant paths above are purely combinational.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      active      <= 1'b0;
      ar_lock     <= 1'b0;
      ar_lock_sel <= SEL_M0;
      aw_lock     <= 1'b0;
      aw_lock_sel <= SEL_M0;
    end else begin
      active      <= 1'b1;
      // Keep the grant while an address is presented but not yet accepted.
      ar_lock     <= ar_gvalid & ~s_arready;
      ar_lock_sel <= ar_grant;
      aw_lock     <= aw_gvalid & ~s_awready;
      aw_lock_sel <= aw_grant;
    end
  end

`ifdef AXI_MUX_FIXED_PRIO_EN
  assign ar_pref = SEL_M1;
  assign aw_pref = SEL_M1;
`else
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      ar_pref <= SEL_M0;
      aw_pref <= SEL_M0;
    end else begin
      if (ar_hs) ar_pref <= ~ar_grant;
      if (aw_hs) aw_pref <= ~aw_grant;
    end
  end
`endif

endmodule

// File: tb/tb_axi_2to1_master_mux.sv
// Self-checking bench for axi_2to1_master_mux: directed scenarios plus a randomized AR/R phase
// checked against a transaction-level model (priority bit, held-grant rule, tag routing).
module tb_axi_2to1_master_mux;

  localparam int IDW = 8;

  logic clk = 1'b0;
  logic reset_l;
  always #5 clk = ~clk;

  logic            m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
  logic [IDW-1:0]  m0_arid, m0_rid, m0_awid, m0_bid;
  logic [31:0]     m0_araddr, m0_awaddr;
  logic [63:0]     m0_rdata, m0_wdata;
  logic [1:0]      m0_rresp, m0_bresp;
  logic            m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_bvalid, m0_bready;
  logic [7:0]      m0_wstrb;
  logic            m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
  logic [IDW-1:0]  m1_arid, m1_rid, m1_awid, m1_bid;
  logic [31:0]     m1_araddr, m1_awaddr;
  logic [63:0]     m1_rdata, m1_wdata;
  logic [1:0]      m1_rresp, m1_bresp;
  logic            m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic [7:0]      m1_wstrb;
  logic            s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [IDW:0]    s_arid, s_rid, s_awid, s_bid;
  logic [31:0]     s_araddr, s_awaddr;
  logic [63:0]     s_rdata, s_wdata;
  logic [1:0]      s_rresp, s_bresp;
  logic            s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [7:0]      s_wstrb;

  axi_2to1_master_mux #(.M_ID_WIDTH(IDW), .WSEL_DEPTH(4)) dut (
    .clk(clk), .reset_l(reset_l),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_arid(m0_arid), .m0_araddr(m0_araddr),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rid(m0_rid),
    .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m0_awvalid(m0_awvalid), .m0_awready(m0_awready), .m0_awid(m0_awid), .m0_awaddr(m0_awaddr),
    .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_bvalid(m0_bvalid), .m0_bready(m0_bready), .m0_bid(m0_bid), .m0_bresp(m0_bresp),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_arid(m1_arid), .m1_araddr(m1_araddr),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rid(m1_rid),
    .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awid(m1_awid), .m1_awaddr(m1_awaddr),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bid(m1_bid), .m1_bresp(m1_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rid(s_rid),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp)
  );

  logic [14:0] ctl_vec;
  assign ctl_vec = {m0_arready, m1_arready, m0_rvalid, m1_rvalid, m0_awready, m1_awready,
                    m0_wready, m1_wready, m0_bvalid, m1_bvalid,
                    s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready};

  int   total = 0;
  int   bad   = 0;
  logic exp_ar_pref, exp_aw_pref;   // model: who wins the next contended request

  function automatic logic pick(input logic pref);
`ifdef AXI_MUX_FIXED_PRIO_EN
    return 1'b1;
`else
    return pref;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    m0_arvalid = 0; m0_arid = '0; m0_araddr = '0; m0_rready = 1;
    m0_awvalid = 0; m0_awid = '0; m0_awaddr = '0; m0_wvalid = 0; m0_wdata = '0; m0_wstrb = '0;
    m0_bready = 1;
    m1_arvalid = 0; m1_arid = '0; m1_araddr = '0; m1_rready = 1;
    m1_awvalid = 0; m1_awid = '0; m1_awaddr = '0; m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0;
    m1_bready = 1;
    s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rid = '0; s_rresp = '0; s_rlast = 0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bid = '0; s_bresp = '0;
  endtask

  task automatic do_reset();
    idle();
    reset_l = 0;
    repeat (2) @(posedge clk);
    #1 reset_l = 1;
    tick();
    exp_ar_pref = 0;
    exp_aw_pref = 0;
  endtask

  task automatic test_reset();
    idle();
    reset_l = 0;
    m0_arvalid = 1; m1_awvalid = 1; m0_wvalid = 1; s_rvalid = 1; s_bvalid = 1;
    s_arready = 1; s_awready = 1; s_wready = 1;
    repeat (2) @(posedge clk);
    settle();
    total++;
    if (ctl_vec !== 15'h0) begin
      bad++; $display("FAIL reset_outputs got=%h want=%h", ctl_vec, 15'h0);
    end
    do_reset();
    total++;
    if (ctl_vec !== 15'b000000_0000_01001) begin
      bad++; $display("FAIL idle_after_reset got=%b want=%b", ctl_vec, 15'b000000_0000_01001);
    end
  endtask

  task automatic test_ar_single();
    logic [63:0] d;
    m0_arvalid = 1; m0_araddr = 32'h1000; m0_arid = 8'h05; s_arready = 1;
    settle();
    total++;
    if ({s_arvalid, s_arid, s_araddr} !== {1'b1, 9'h005, 32'h1000}) begin
      bad++; $display("FAIL ar_single got=%b/%h/%h want=1/005/00001000", s_arvalid, s_arid, s_araddr);
    end
    total++;
    if ({m0_arready, m1_arready} !== 2'b10) begin
      bad++; $display("FAIL ar_single_ready got=%b want=10", {m0_arready, m1_arready});
    end
    tick();
    exp_ar_pref = 1;
    idle();
    d = {$urandom, $urandom};
    s_rvalid = 1; s_rid = 9'h005; s_rdata = d; s_rresp = 2'b01; s_rlast = 1;
    settle();
    total++;
    if ({m0_rvalid, m1_rvalid, m0_rid, m0_rdata, m0_rresp, m0_rlast, s_rready} !==
        {1'b1, 1'b0, 8'h05, d, 2'b01, 1'b1, 1'b1}) begin
      bad++; $display("FAIL r_route_m0 got=%b%b %h %h want=10 05 %h", m0_rvalid, m1_rvalid,
                      m0_rid, m0_rdata, d);
    end
    tick();
    idle();
  endtask

  task automatic test_ar_rr();
    logic g;
    do_reset();
    m0_arvalid = 1; m0_araddr = 32'h2000; m0_arid = 8'h11;
    m1_arvalid = 1; m1_araddr = 32'h3000; m1_arid = 8'h22;
    s_arready = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      g = pick(exp_ar_pref);
      total++;
      if ({s_arid, s_araddr} !== {g, g ? 8'h22 : 8'h11, g ? 32'h3000 : 32'h2000}) begin
        bad++; $display("FAIL ar_rr[%0d] got=%h/%h want_master=%0d", i, s_arid, s_araddr, g);
      end
      tick();
      exp_ar_pref = ~g;
    end
    idle();
  endtask

  task automatic test_ar_stall();
    logic [7:0] id0;
    id0 = 8'($urandom);
    m0_arvalid = 1; m0_araddr = 32'h4000; m0_arid = id0;
    m1_araddr = 32'h5000; m1_arid = 8'h77;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) m1_arvalid = 1;
      settle();
      total++;
      if ({s_arvalid, s_arid, s_araddr, m1_arready} !== {1'b1, 1'b0, id0, 32'h4000, 1'b0}) begin
        bad++; $display("FAIL ar_stall[%0d] got=%b/%h/%h/%b want=1/0%h/00004000/0", i,
                        s_arvalid, s_arid, s_araddr, m1_arready, id0);
      end
      tick();
    end
    s_arready = 1;
    settle();
    total++;
    if ({m0_arready, m1_arready} !== 2'b10) begin
      bad++; $display("FAIL ar_stall_release got=%b want=10", {m0_arready, m1_arready});
    end
    tick();
    exp_ar_pref = 1;
    m0_arvalid = 0;
    settle();
    total++;
    if ({s_arid, s_araddr} !== {9'h177, 32'h5000}) begin
      bad++; $display("FAIL ar_after_stall got=%h/%h want=177/00005000", s_arid, s_araddr);
    end
    tick();
    exp_ar_pref = 0;
    idle();
  endtask

  task automatic drive_aw(input logic sel, input logic [7:0] id);
    m0_awvalid = !sel; m1_awvalid = sel;
    m0_awid = id; m1_awid = id;
    m0_awaddr = {24'h0, id}; m1_awaddr = {24'h1, id};
  endtask

  task automatic test_aw_fifo();
    logic q[$];
    logic sel, h, rdy;
    logic [63:0] d0, d1;
    do_reset();
    d0 = {$urandom, $urandom}; d1 = ~d0;
    m0_wdata = d0; m1_wdata = d1; m0_wstrb = 8'h0F; m1_wstrb = 8'hF0;
    s_awready = 1;
    for (int i = 0; i < 4; i++) begin
      sel = 1'($urandom_range(0, 1));
      drive_aw(sel, 8'(i));
      settle();
      rdy = sel ? m1_awready : m0_awready;
      total++;
      if ({s_awvalid, s_awid, rdy} !== {1'b1, sel, 8'(i), 1'b1}) begin
        bad++; $display("FAIL aw_accept[%0d] got=%b/%h/%b want=1/%h/1", i, s_awvalid, s_awid,
                        rdy, {sel, 8'(i)});
      end
      tick();
      q.push_back(sel);
    end
    sel = 1'($urandom_range(0, 1));
    drive_aw(sel, 8'h44);
    for (int i = 0; i < 2; i++) begin
      settle();
      total++;
      if ({s_awvalid, m0_awready, m1_awready} !== 3'b000) begin
        bad++; $display("FAIL aw_full[%0d] got=%b want=000", i, {s_awvalid, m0_awready, m1_awready});
      end
      tick();
    end
    m0_wvalid = 1; m1_wvalid = 1; s_wready = 1;
    settle();
    h = q.pop_front();
    total++;
    if ({s_wvalid, s_wdata, s_wstrb, m0_wready, m1_wready} !==
        {1'b1, h ? d1 : d0, h ? 8'hF0 : 8'h0F, !h, h}) begin
      bad++; $display("FAIL w_first got=%b/%h/%b%b want_master=%0d", s_wvalid, s_wdata,
                      m0_wready, m1_wready, h);
    end
    tick();
    s_wready = 0;
    settle();
    rdy = sel ? m1_awready : m0_awready;
    total++;
    if ({s_awvalid, rdy} !== 2'b11) begin
      bad++; $display("FAIL aw_after_pop got=%b want=11", {s_awvalid, rdy});
    end
    tick();
    q.push_back(sel);
    m0_awvalid = 0; m1_awvalid = 0;
    s_wready = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      h = q.pop_front();
      total++;
      if ({s_wvalid, s_wdata} !== {1'b1, h ? d1 : d0}) begin
        bad++; $display("FAIL w_order[%0d] got=%b/%h want_master=%0d", i, s_wvalid, s_wdata, h);
      end
      tick();
    end
    settle();
    total++;
    if ({s_wvalid, m0_wready, m1_wready} !== 3'b000) begin
      bad++; $display("FAIL w_drained got=%b want=000", {s_wvalid, m0_wready, m1_wready});
    end
    idle();
  endtask

  task automatic test_w_bypass();
    logic [63:0] d;
    d = {$urandom, $urandom};
    s_awready = 1; s_wready = 1;
    m1_awvalid = 1; m1_awid = 8'h3C; m1_wvalid = 1; m1_wdata = d; m1_wstrb = 8'hAA;
    m0_wdata = ~d;
    settle();
    total++;
    if ({s_wvalid, s_wdata, s_wstrb, m1_wready, m0_wready, m1_awready} !==
        {1'b1, d, 8'hAA, 1'b1, 1'b0, 1'b1}) begin
      bad++; $display("FAIL w_bypass got=%b/%h/%b%b%b want=1/%h/101", s_wvalid, s_wdata,
                      m1_wready, m0_wready, m1_awready, d);
    end
    tick();
    idle();
    m0_wvalid = 1; s_wready = 1;
    settle();
    total++;
    if ({s_wvalid, m0_wready, m1_wready} !== 3'b000) begin
      bad++; $display("FAIL w_bypass_empty got=%b want=000", {s_wvalid, m0_wready, m1_wready});
    end
    idle();
  endtask

  task automatic test_b_route();
    s_bvalid = 1; s_bid = 9'h1A3; s_bresp = 2'b10; m1_bready = 1; m0_bready = 0;
    settle();
    total++;
    if ({m1_bvalid, m0_bvalid, m1_bid, m1_bresp, s_bready} !== {2'b10, 8'hA3, 2'b10, 1'b1}) begin
      bad++; $display("FAIL b_route_m1 got=%b%b/%h/%b/%b want=10/a3/10/1", m1_bvalid, m0_bvalid,
                      m1_bid, m1_bresp, s_bready);
    end
    m1_bready = 0; m0_bready = 1;
    settle();
    total++;
    if (s_bready !== 1'b0) begin
      bad++; $display("FAIL b_ready_follow got=%b want=0", s_bready);
    end
    s_bid = 9'h0A3; s_bresp = 2'b00;
    settle();
    total++;
    if ({m0_bvalid, m1_bvalid, m0_bid, m0_bresp, s_bready} !== {2'b10, 8'hA3, 2'b00, 1'b1}) begin
      bad++; $display("FAIL b_route_m0 got=%b%b/%h/%b/%b want=10/a3/00/1", m0_bvalid, m1_bvalid,
                      m0_bid, m0_bresp, s_bready);
    end
    tick();
    idle();
  endtask

  task automatic test_random();
    logic       pend[2];
    logic [7:0] id[2];
    logic [31:0] ad[2];
    logic       held, held_sel, g, v;
    logic [8:0] rid;
    pend[0] = 0; pend[1] = 0; held = 0; held_sel = 0;
    for (int c = 0; c < 300; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(0, 2) == 0) begin
          pend[m] = 1; id[m] = 8'($urandom); ad[m] = $urandom;
        end
      end
      m0_arvalid = pend[0]; m0_arid = id[0]; m0_araddr = ad[0];
      m1_arvalid = pend[1]; m1_arid = id[1]; m1_araddr = ad[1];
      s_arready = 1'($urandom_range(0, 1));
      rid = 9'($urandom);
      s_rvalid = 1'($urandom_range(0, 1)); s_rid = rid; s_rdata = {$urandom, $urandom};
      m0_rready = 1'($urandom_range(0, 1)); m1_rready = 1'($urandom_range(0, 1));
      settle();
      v = pend[0] | pend[1];
      if (held)                  g = held_sel;
      else if (pend[0] && pend[1]) g = pick(exp_ar_pref);
      else                       g = pend[1];
      total++;
      if (s_arvalid !== v || (v && {s_arid, s_araddr} !== {g, id[g], ad[g]})) begin
        bad++; $display("FAIL rand_ar[%0d] got=%b/%h/%h want=%b/%h/%h", c, s_arvalid, s_arid,
                        s_araddr, v, {g, id[g]}, ad[g]);
      end
      total++;
      if ({m0_rvalid, m1_rvalid, s_rready, m1_rid} !==
          {s_rvalid & ~rid[8], s_rvalid & rid[8], rid[8] ? m1_rready : m0_rready, rid[7:0]}) begin
        bad++; $display("FAIL rand_r[%0d] got=%b%b%b/%h rid=%h", c, m0_rvalid, m1_rvalid,
                        s_rready, m1_rid, rid);
      end
      held = v & ~s_arready;
      held_sel = g;
      if (v && s_arready) begin
        exp_ar_pref = ~g;
        pend[g] = 0;
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    s_awready = 1; s_wready = 0;
    for (int i = 0; i < 2; i++) begin
      m0_awvalid = 1; m0_awid = 8'(i);
      tick();
    end
    m0_awvalid = 0;
    m0_arvalid = 1; m1_arvalid = 1; s_arready = 0; s_rvalid = 1; s_bvalid = 1; m0_wvalid = 1;
    tick();
    #1 reset_l = 0;
    settle();
    total++;
    if (ctl_vec !== 15'h0) begin
      bad++; $display("FAIL reset_mid got=%h want=%h", ctl_vec, 15'h0);
    end
    repeat (2) @(posedge clk);
    #1 reset_l = 1;
    s_rvalid = 0; s_bvalid = 0; s_wready = 1;
    exp_ar_pref = 0;
    tick();
    settle();
    total++;
    if ({s_wvalid, m0_wready} !== 2'b00) begin
      bad++; $display("FAIL reset_mid_fifo got=%b want=00", {s_wvalid, m0_wready});
    end
    total++;
    if ({s_arvalid, s_arid[IDW]} !== {1'b1, pick(exp_ar_pref)}) begin
      bad++; $display("FAIL reset_mid_rr got=%b/%b want=1/%b", s_arvalid, s_arid[IDW],
                      pick(exp_ar_pref));
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_ar_single();
    test_ar_rr();
    test_ar_stall();
    test_aw_fifo();
    test_w_bypass();
    test_b_route();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
